mem_arbiter: RTL and testbench

//  Shares one fixed-latency, pipelined main memory between two requesters:
//   - the instruction-cache fill port (I)
//   - the data-cache fill/write-through port (D)

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_lat_pipe.sv | 45 ++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the I/D memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int BLK_WORDS_DEF = 8;
  localparam int MEM_LAT_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // On contention the requester that did not win last time gets the grant.
  function automatic owner_e rr_pick(input owner_e last);
    return (last == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// Tracks in-flight memory reads: a DEPTH-deep shift register of
// {valid, owner, word index} aligned with the memory's read latency.
module mem_lat_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LAT_DEF,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  owner_e           owner_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output owner_e           owner_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            owner_q;
  logic [DEPTH-1:0][IDX_W-1:0] idx_q;

  // Shift one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      owner_q[0] <= owner_i;
      idx_q[0]   <= idx_i;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        owner_q[s] <= owner_q[s-1];
        idx_q[s]   <= idx_q[s-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign owner_o = owner_e'(owner_q[DEPTH-1]);
  assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined fixed-latency memory between the I-cache fill port
// and the D-cache fill/write-through port. Block fills issue one read per
// cycle; returned words are steered to the owner, which gets a done pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLK_WORDS = BLK_WORDS_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         i_fill_valid,
  output logic                         d_fill_valid,
  output logic [DATA_W-1:0]            fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int IDX_W = $clog2(BLK_WORDS);
  // One extra bit so the issue counter can hold BLK_WORDS ("all issued").
  localparam int CNT_W = IDX_W + 1;
  // Byte offset within a block of 2*BLK_WORDS bytes.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << (IDX_W + 1)) - 1);

  state_e              state_q, state_d;
  owner_e              owner_q, last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                grant_v;
  owner_e              grant_own;
  logic                issue_en;
  logic [ADDR_W-1:0]   base_addr;
  logic                pipe_valid;
  owner_e              pipe_owner;
  logic [IDX_W-1:0]    pipe_idx;
  logic                fill_last;

  assign issue_en  = (state_q == ST_FILL) && !cnt_q[CNT_W-1];
  assign base_addr = addr_q & ~OFF_MASK;
  assign fill_last = pipe_valid && (pipe_idx == IDX_W'(BLK_WORDS - 1));

  mem_lat_pipe #(
    .DEPTH (MEM_LAT),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (issue_en),
    .owner_i (owner_q),
    .idx_i   (cnt_q[IDX_W-1:0]),
    .valid_o (pipe_valid),
    .owner_o (pipe_owner),
    .idx_o   (pipe_idx)
  );

  // Arbitrate pending requests while idle; alternate on contention.
  always_comb begin
    grant_v   = 1'b0;
    grant_own = OWN_I;
    if (state_q == ST_IDLE) begin
      if (i_req && d_req) begin
        grant_v   = 1'b1;
        grant_own = rr_pick(last_grant_q);
      end else if (i_req) begin
        grant_v   = 1'b1;
        grant_own = OWN_I;
      end else if (d_req) begin
        grant_v   = 1'b1;
        grant_own = OWN_D;
      end
    end
  end

  // State register plus the transaction captured at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (grant_v) begin
        owner_q      <= grant_own;
        last_grant_q <= grant_own;
        addr_q       <= (grant_own == OWN_I) ? i_addr : d_addr;
        wdata_q      <= d_wdata;
        cnt_q        <= '0;
      end else if (issue_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state: a fill ends with its last returned word, a write after one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_v) begin
          state_d = (grant_own == OWN_D && d_wr) ? ST_WRITE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_last) state_d = ST_IDLE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state and the return pipe.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_data    = '0;
    fill_idx     = '0;
    case (state_q)
      ST_FILL: begin
        if (issue_en) begin
          mem_en   = 1'b1;
          mem_addr = base_addr + ADDR_W'({cnt_q[IDX_W-1:0], 1'b0});
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
      end
      default: ;
    endcase
    if (pipe_valid) begin
      fill_data    = mem_rdata;
      fill_idx     = pipe_idx;
      i_fill_valid = (pipe_owner == OWN_I);
      d_fill_valid = (pipe_owner == OWN_D);
      i_done       = fill_last && (pipe_owner == OWN_I);
      d_done       = fill_last && (pipe_owner == OWN_D);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: default instance (BLK=8, LAT=4) plus a
// small instance (BLK=4, LAT=1) for the address-wrap case.
module tb_mem_arbiter;

  localparam int LAT  = 4;
  localparam int BLK  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT1 signals
  logic        i_req = 0, d_req = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_fill_valid, d_fill_valid, i_done, d_done, mem_en, mem_wr;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_idx;
  // DUT2 signals
  logic        i_req2 = 0, d_req2 = 0, d_wr2 = 0;
  logic [15:0] i_addr2 = 0, d_addr2 = 0, d_wdata2 = 0;
  logic        i_fill_valid2, d_fill_valid2, i_done2, d_done2, mem_en2, mem_wr2;
  logic [15:0] fill_data2, mem_addr2, mem_wdata2, mem_rdata2;
  logic [1:0]  fill_idx2;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8), .MEM_LAT(4)) u_dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_fill_valid(i_fill_valid),
    .d_fill_valid(d_fill_valid), .fill_data(fill_data), .fill_idx(fill_idx),
    .i_done(i_done), .d_done(d_done), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(4), .MEM_LAT(1)) u_dut2 (
    .clk(clk), .rst(rst), .i_req(i_req2), .i_addr(i_addr2), .d_req(d_req2), .d_wr(d_wr2),
    .d_addr(d_addr2), .d_wdata(d_wdata2), .i_fill_valid(i_fill_valid2),
    .d_fill_valid(d_fill_valid2), .fill_data(fill_data2), .fill_idx(fill_idx2),
    .i_done(i_done2), .d_done(d_done2), .mem_en(mem_en2), .mem_wr(mem_wr2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2));

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory models: read data appears LAT cycles after the issue cycle.
  logic [15:0] rpipe [LAT] = '{default: 16'hDEAD};
  always @(posedge clk) begin
    rpipe[0] <= (mem_en && !mem_wr) ? memf(mem_addr) : 16'hDEAD;
    for (int s = 1; s < LAT; s++) rpipe[s] <= rpipe[s-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  logic [15:0] rdata2 = 16'hDEAD;
  always @(posedge clk) rdata2 <= (mem_en2 && !mem_wr2) ? memf(mem_addr2) : 16'hDEAD;
  assign mem_rdata2 = rdata2;

  typedef struct { int cyc; logic [15:0] addr; logic wr; logic [15:0] wdata; } iss_t;
  typedef struct { int cyc; logic own_d; logic [2:0] idx; logic [15:0] data; } fill_t;
  typedef struct { int cyc; logic own_d; } done_t;

  iss_t  q_iss[$];
  fill_t q_fill[$];
  done_t q_done[$];
  iss_t  e_iss;
  fill_t e_fill;
  done_t e_done;

  // DUT1 monitor: every issue / returned word / done pops the scoreboard.
  always @(negedge clk) begin
    if (mem_en) begin
      checks++;
      if (q_iss.size() == 0) begin
        failures++;
        $display("FAIL issue: unexpected access cyc=%0d addr=%h wr=%b", cyc, mem_addr, mem_wr);
      end else begin
        e_iss = q_iss.pop_front();
        if (cyc != e_iss.cyc || mem_addr !== e_iss.addr || mem_wr !== e_iss.wr ||
            (e_iss.wr && mem_wdata !== e_iss.wdata)) begin
          failures++;
          $display("FAIL issue: got cyc=%0d addr=%h wr=%b wdata=%h, want cyc=%0d addr=%h wr=%b wdata=%h",
                   cyc, mem_addr, mem_wr, mem_wdata, e_iss.cyc, e_iss.addr, e_iss.wr, e_iss.wdata);
        end
      end
    end
    if (i_fill_valid || d_fill_valid) begin
      checks++;
      if (q_fill.size() == 0) begin
        failures++;
        $display("FAIL fill: unexpected word cyc=%0d iv=%b dv=%b idx=%0d", cyc, i_fill_valid, d_fill_valid, fill_idx);
      end else begin
        e_fill = q_fill.pop_front();
        if (cyc != e_fill.cyc || i_fill_valid !== !e_fill.own_d || d_fill_valid !== e_fill.own_d ||
            fill_idx !== e_fill.idx || fill_data !== e_fill.data) begin
          failures++;
          $display("FAIL fill: got cyc=%0d iv=%b dv=%b idx=%0d data=%h, want cyc=%0d own_d=%b idx=%0d data=%h",
                   cyc, i_fill_valid, d_fill_valid, fill_idx, fill_data,
                   e_fill.cyc, e_fill.own_d, e_fill.idx, e_fill.data);
        end
      end
    end
    if (i_done || d_done) begin
      checks++;
      if (q_done.size() == 0) begin
        failures++;
        $display("FAIL done: unexpected cyc=%0d i_done=%b d_done=%b", cyc, i_done, d_done);
      end else begin
        e_done = q_done.pop_front();
        if (cyc != e_done.cyc || i_done !== !e_done.own_d || d_done !== e_done.own_d) begin
          failures++;
          $display("FAIL done: got cyc=%0d i=%b d=%b, want cyc=%0d own_d=%b",
                   cyc, i_done, d_done, e_done.cyc, e_done.own_d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected issues/returns/done of a DUT1 fill granted in cycle t.
  task automatic push_fill(input int t, input logic own_d, input logic [15:0] addr,
                           input int n_iss, input int n_ret, input bit with_done);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < n_iss; k++)
      q_iss.push_back('{t + 1 + k, base + 16'(2 * k), 1'b0, 16'h0000});
    for (int k = 0; k < n_ret; k++)
      q_fill.push_back('{t + 1 + k + LAT, own_d, 3'(k), memf(base + 16'(2 * k))});
    if (with_done) q_done.push_back('{t + BLK + LAT, own_d});
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req2 = 0; d_req2 = 0; d_wr2 = 0; i_addr2 = 0; d_addr2 = 0; d_wdata2 = 0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q_iss.size() != 0 || q_fill.size() != 0 || q_done.size() != 0) begin
      failures++;
      $display("FAIL %s: pending expectations iss=%0d fill=%0d done=%0d, want 0/0/0",
               name, q_iss.size(), q_fill.size(), q_done.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    checks++;
    if ({i_fill_valid, d_fill_valid, fill_data, fill_idx, i_done, d_done,
         mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: dut1 outputs not all zero (mem_en=%b addr=%h)", mem_en, mem_addr);
    end
    checks++;
    if ({i_fill_valid2, d_fill_valid2, fill_data2, fill_idx2, i_done2, d_done2,
         mem_en2, mem_wr2, mem_addr2, mem_wdata2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs2: dut2 outputs not all zero (mem_en=%b addr=%h)", mem_en2, mem_addr2);
    end
    rst = 0;
  endtask

  task automatic test_i_fill();
    int t0;
    test_reset();
    t0 = cyc;
    push_fill(t0, 1'b0, 16'h1234, 8, 8, 1);
    for (int c = 0; c < 18; c++) begin
      i_req  = (c < 13);
      i_addr = (c == 0) ? 16'h1234 : 16'h9999;
      step();
    end
    check_drained("i_fill");
  endtask

  task automatic test_write_back_to_back();
    int t0;
    test_reset();
    t0 = cyc;
    q_iss.push_back('{t0 + 1, 16'h0040, 1'b1, 16'hBEEF});
    q_done.push_back('{t0 + 1, 1'b1});
    push_fill(t0 + 2, 1'b0, 16'h00F6, 8, 8, 1);
    for (int c = 0; c < 20; c++) begin
      d_req   = (c < 2);
      d_wr    = 1;
      d_addr  = (c == 0) ? 16'h0040 : 16'h7777;
      d_wdata = (c == 0) ? 16'hBEEF : 16'h1111;
      i_req   = (c >= 1 && c < 15);
      i_addr  = 16'h00F6;
      step();
    end
    check_drained("write_back_to_back");
  endtask

  task automatic test_both_fill();
    int t0;
    test_reset();
    t0 = cyc;
    push_fill(t0, 1'b1, 16'hABCD, 8, 8, 1);
    push_fill(t0 + 13, 1'b0, 16'h2222, 8, 8, 1);
    for (int c = 0; c < 30; c++) begin
      d_req = (c < 13); d_wr = 0; d_addr = 16'hABCD;
      i_req = (c < 26); i_addr = 16'h2222;
      step();
    end
    check_drained("both_fill");
  endtask

  task automatic test_round_robin();
    int t0;
    test_reset();
    t0 = cyc;
    for (int g = 0; g < 4; g++)
      push_fill(t0 + 13 * g, (g % 2 == 0), (g % 2 == 0) ? 16'h031F : 16'h0200, 8, 8, 1);
    for (int c = 0; c < 56; c++) begin
      d_req = (c < 52); d_wr = 0; d_addr = 16'h031F;
      i_req = (c < 52); i_addr = 16'h0200;
      step();
    end
    check_drained("round_robin");
  endtask

  task automatic test_reset_mid();
    int t0;
    test_reset();
    t0 = cyc;
    push_fill(t0, 1'b0, 16'h1234, 6, 2, 0);
    for (int c = 0; c < 7; c++) begin
      i_req  = (c < 6);
      i_addr = 16'h1234;
      rst    = (c == 6);
      step();
    end
    rst = 0;
    checks++;
    if ({i_fill_valid, d_fill_valid, fill_data, fill_idx, i_done, d_done,
         mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: cycle after rst not all zero (mem_en=%b iv=%b)", mem_en, i_fill_valid);
    end
    for (int c = 7; c < 20; c++) step();
    check_drained("reset_mid");
  endtask

  task automatic test_small_block();
    int t0;
    iss_t  q2_iss[$];
    fill_t q2_fill[$];
    done_t q2_done[$];
    iss_t  ei;
    fill_t ef;
    done_t ed;
    test_reset();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      q2_iss.push_back('{t0 + 1 + k, 16'hFFF8 + 16'(2 * k), 1'b0, 16'h0000});
      q2_fill.push_back('{t0 + 2 + k, 1'b1, 3'(k), memf(16'hFFF8 + 16'(2 * k))});
    end
    q2_done.push_back('{t0 + 5, 1'b1});
    for (int c = 0; c < 10; c++) begin
      d_req2 = (c < 6); d_wr2 = 0; d_addr2 = 16'hFFFA;
      #3;
      if (mem_en2) begin
        checks++;
        ei = (q2_iss.size() != 0) ? q2_iss.pop_front() : '{-1, 16'h0, 1'b0, 16'h0};
        if (cyc != ei.cyc || mem_addr2 !== ei.addr || mem_wr2 !== ei.wr) begin
          failures++;
          $display("FAIL small_issue: got cyc=%0d addr=%h wr=%b, want cyc=%0d addr=%h wr=%b",
                   cyc, mem_addr2, mem_wr2, ei.cyc, ei.addr, ei.wr);
        end
      end
      if (i_fill_valid2 || d_fill_valid2) begin
        checks++;
        ef = (q2_fill.size() != 0) ? q2_fill.pop_front() : '{-1, 1'b0, 3'd0, 16'h0};
        if (cyc != ef.cyc || d_fill_valid2 !== ef.own_d || i_fill_valid2 !== !ef.own_d ||
            {1'b0, fill_idx2} !== ef.idx || fill_data2 !== ef.data) begin
          failures++;
          $display("FAIL small_fill: got cyc=%0d iv=%b dv=%b idx=%0d data=%h, want cyc=%0d idx=%0d data=%h",
                   cyc, i_fill_valid2, d_fill_valid2, fill_idx2, fill_data2, ef.cyc, ef.idx, ef.data);
        end
      end
      if (i_done2 || d_done2) begin
        checks++;
        ed = (q2_done.size() != 0) ? q2_done.pop_front() : '{-1, 1'b0};
        if (cyc != ed.cyc || d_done2 !== ed.own_d || i_done2 !== !ed.own_d) begin
          failures++;
          $display("FAIL small_done: got cyc=%0d i=%b d=%b, want cyc=%0d own_d=%b",
                   cyc, i_done2, d_done2, ed.cyc, ed.own_d);
        end
      end
      step();
    end
    checks++;
    if (q2_iss.size() != 0 || q2_fill.size() != 0 || q2_done.size() != 0) begin
      failures++;
      $display("FAIL small_drained: pending iss=%0d fill=%0d done=%0d, want 0/0/0",
               q2_iss.size(), q2_fill.size(), q2_done.size());
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_write_back_to_back();
    test_both_fill();
    test_round_robin();
    test_reset_mid();
    test_small_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
